// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, opcodes and
// the mux-select / ALU-op codes that the datapath and ALU control also decode.
package mc_ctrl_pkg;

  localparam int OPC_W = 6;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_R_WB     = 4'd7,
    S_EXEC_I   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUSRCB_REG      = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR     = 2'b01;
  localparam logic [1:0] ALUSRCB_SEXT     = 2'b10;
  localparam logic [1:0] ALUSRCB_SEXT_SH2 = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic op_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control-unit <-> datapath bundle: IR opcode and status in, control word out.
interface multicycle_control_fsm_if #(parameter int OPC_W = 6);
  logic [OPC_W-1:0] opcode;
  logic             zero;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic             iord;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             mem_to_reg;
  logic             reg_dst;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_source;
  logic             instr_done;
  logic             illegal_op;
  logic [3:0]       state_dbg;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, illegal_op, state_dbg
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, illegal_op, state_dbg
  );
endinterface

// File: rtl/multicycle_control_fsm_decode.sv
// Combinational state -> control word decode. mem_rdy is the effective
// (already MEM_WAIT_EN-qualified) memory handshake.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_e state,
  input  logic   mem_rdy,
  input  logic   op_ok,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = ALUSRCB_FOUR;
        ctrl.ir_write  = mem_rdy;
        ctrl.pc_write  = mem_rdy;
      end
      S_DECODE: begin
        // branch target precomputed here while the opcode is decoded
        ctrl.alu_src_b  = ALUSRCB_SEXT_SH2;
        ctrl.illegal_op = !op_ok;
        ctrl.instr_done = !op_ok;
      end
      S_MEM_ADDR, S_EXEC_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUSRCB_SEXT;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = mem_rdy;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUSRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_I_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = ALUSRCB_REG;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control FSM: state register and next-state logic; the
// control word itself comes from mc_ctrl_decode.
module multicycle_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter int OPC_W       = 6
) (
  input logic                       clk,
  input logic                       reset,
  multicycle_control_fsm_if.master  bus
);

  state_e           state, state_nxt;
  logic             rdy;
  logic [OPC_W-1:0] op;
  ctrl_t            ctrl;

  assign rdy = MEM_WAIT_EN ? bus.mem_ready : 1'b1;
  assign op  = bus.opcode;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_FETCH;
    unique case (state)
      S_FETCH:    state_nxt = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (op)
          OP_RTYPE:     state_nxt = S_EXEC_R;
          OP_LW, OP_SW: state_nxt = S_MEM_ADDR;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_J:         state_nxt = S_JUMP;
          OP_ADDI:      state_nxt = S_EXEC_I;
          default:      state_nxt = S_FETCH;
        endcase
      end
      S_MEM_ADDR: state_nxt = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_nxt = rdy ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   state_nxt = rdy ? S_FETCH : S_MEM_WR;
      S_EXEC_R:   state_nxt = S_R_WB;
      S_EXEC_I:   state_nxt = S_I_WB;
      // writeback, branch, jump and any stray encoding return to fetch
      default:    state_nxt = S_FETCH;
    endcase
  end

  mc_ctrl_decode u_decode (
    .state   (state),
    .mem_rdy (rdy),
    .op_ok   (op_legal(op)),
    .ctrl    (ctrl)
  );

  assign bus.pc_write      = ctrl.pc_write;
  assign bus.pc_write_cond = ctrl.pc_write_cond;
  assign bus.iord          = ctrl.iord;
  assign bus.mem_read      = ctrl.mem_read;
  assign bus.mem_write     = ctrl.mem_write;
  assign bus.ir_write      = ctrl.ir_write;
  assign bus.mem_to_reg    = ctrl.mem_to_reg;
  assign bus.reg_dst       = ctrl.reg_dst;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.alu_src_a     = ctrl.alu_src_a;
  assign bus.alu_src_b     = ctrl.alu_src_b;
  assign bus.alu_op        = ctrl.alu_op;
  assign bus.pc_source     = ctrl.pc_source;
  assign bus.instr_done    = ctrl.instr_done;
  assign bus.illegal_op    = ctrl.illegal_op;
  assign bus.state_dbg     = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: per-cycle vector table on a waiting and a
// non-waiting instance, plus a stalled-lw sequence.
module tb_multicycle_control_fsm;
  import mc_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst0, rst1;
  always #5 clk = ~clk;

  multicycle_control_fsm_if #(.OPC_W(6)) bus0();
  multicycle_control_fsm_if #(.OPC_W(6)) bus1();

  multicycle_control_fsm #(.MEM_WAIT_EN(1'b1), .OPC_W(6)) dut0 (.clk(clk), .reset(rst0), .bus(bus0));
  multicycle_control_fsm #(.MEM_WAIT_EN(1'b0), .OPC_W(6)) dut1 (.clk(clk), .reset(rst1), .bus(bus1));

  // {state, pw, pwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc, done, ill}
  logic [21:0] obs0, obs1;
  assign obs0 = {bus0.state_dbg, bus0.pc_write, bus0.pc_write_cond, bus0.iord, bus0.mem_read,
                 bus0.mem_write, bus0.ir_write, bus0.mem_to_reg, bus0.reg_dst, bus0.reg_write,
                 bus0.alu_src_a, bus0.alu_src_b, bus0.alu_op, bus0.pc_source, bus0.instr_done,
                 bus0.illegal_op};
  assign obs1 = {bus1.state_dbg, bus1.pc_write, bus1.pc_write_cond, bus1.iord, bus1.mem_read,
                 bus1.mem_write, bus1.ir_write, bus1.mem_to_reg, bus1.reg_dst, bus1.reg_write,
                 bus1.alu_src_a, bus1.alu_src_b, bus1.alu_op, bus1.pc_source, bus1.instr_done,
                 bus1.illegal_op};

  //                                 pw pwc io mr mw ir m2r rd rw a  asb aop psr dn il
  localparam logic [17:0] C_FRDY = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] C_FWT  = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] C_DEC  = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [17:0] C_DILL = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_1_1;
  localparam logic [17:0] C_MADR = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] C_MRD  = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] C_MWB  = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_1_0;
  localparam logic [17:0] C_MWW  = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] C_MWD  = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_1_0;
  localparam logic [17:0] C_EXR  = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
  localparam logic [17:0] C_RWB  = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_1_0;
  localparam logic [17:0] C_EXI  = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] C_IWB  = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_1_0;
  localparam logic [17:0] C_BR   = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_1_0;
  localparam logic [17:0] C_JMP  = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_1_0;

  typedef struct {
    bit          sel;
    bit          rst;
    logic [5:0]  opc;
    bit          z;
    bit          rdy;
    bit          chk;
    logic [3:0]  st;
    logic [17:0] cw;
  } vec_t;

  vec_t        vt[$];
  logic [21:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          inv_bad = 0;

  task automatic add(input bit sel, input bit rst, input logic [5:0] opc, input bit z,
                     input bit rdy, input bit chk, input state_e st, input logic [17:0] cw);
    vec_t v;
    v.sel = sel; v.rst = rst; v.opc = opc; v.z = z; v.rdy = rdy; v.chk = chk;
    v.st = 4'(st); v.cw = cw;
    vt.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    if (v.sel) begin
      rst1 = v.rst; bus1.opcode = v.opc; bus1.zero = v.z; bus1.mem_ready = v.rdy;
    end else begin
      rst0 = v.rst; bus0.opcode = v.opc; bus0.zero = v.z; bus0.mem_ready = v.rdy;
    end
  endtask

  always @(negedge clk) begin
    if ((bus0.mem_read && bus0.mem_write) || (bus0.pc_write && bus0.pc_write_cond) ||
        (bus1.mem_read && bus1.mem_write) || (bus1.pc_write && bus1.pc_write_cond))
      inv_bad++;
  end

  initial begin
    logic [21:0] e, got;
    int dcnt, wcnt, dcyc;
    rst0 = 1'b1; rst1 = 1'b1;
    bus0.opcode = '0; bus0.zero = 1'b0; bus0.mem_ready = 1'b1;
    bus1.opcode = '0; bus1.zero = 1'b0; bus1.mem_ready = 1'b0;

    // waiting instance: reset, lw, stalled sw, stalled fetch + R, addi, beq x2, j, illegal x2
    add(0, 1, OP_LW,   0, 1, 0, S_FETCH,    C_FRDY);
    add(0, 1, OP_LW,   0, 1, 1, S_FETCH,    C_FRDY);
    add(0, 0, OP_LW,   0, 1, 1, S_FETCH,    C_FRDY);
    add(0, 0, OP_LW,   0, 1, 1, S_DECODE,   C_DEC);
    add(0, 0, OP_LW,   0, 1, 1, S_MEM_ADDR, C_MADR);
    add(0, 0, OP_LW,   0, 1, 1, S_MEM_RD,   C_MRD);
    add(0, 0, OP_LW,   0, 1, 1, S_MEM_WB,   C_MWB);
    add(0, 0, OP_SW,   0, 1, 1, S_FETCH,    C_FRDY);
    add(0, 0, OP_SW,   0, 1, 1, S_DECODE,   C_DEC);
    add(0, 0, OP_SW,   0, 1, 1, S_MEM_ADDR, C_MADR);
    add(0, 0, OP_SW,   0, 0, 1, S_MEM_WR,   C_MWW);
    add(0, 0, OP_SW,   0, 0, 1, S_MEM_WR,   C_MWW);
    add(0, 0, OP_SW,   0, 0, 1, S_MEM_WR,   C_MWW);
    add(0, 0, OP_SW,   0, 1, 1, S_MEM_WR,   C_MWD);
    add(0, 0, OP_RTYPE,0, 0, 1, S_FETCH,    C_FWT);
    add(0, 0, OP_RTYPE,0, 1, 1, S_FETCH,    C_FRDY);
    add(0, 0, OP_RTYPE,0, 1, 1, S_DECODE,   C_DEC);
    add(0, 0, OP_RTYPE,0, 1, 1, S_EXEC_R,   C_EXR);
    add(0, 0, OP_RTYPE,0, 1, 1, S_R_WB,     C_RWB);
    add(0, 0, OP_ADDI, 0, 1, 1, S_FETCH,    C_FRDY);
    add(0, 0, OP_ADDI, 0, 1, 1, S_DECODE,   C_DEC);
    add(0, 0, OP_ADDI, 0, 1, 1, S_EXEC_I,   C_EXI);
    add(0, 0, OP_ADDI, 0, 1, 1, S_I_WB,     C_IWB);
    add(0, 0, OP_BEQ,  1, 1, 1, S_FETCH,    C_FRDY);
    add(0, 0, OP_BEQ,  1, 1, 1, S_DECODE,   C_DEC);
    add(0, 0, OP_BEQ,  1, 1, 1, S_BRANCH,   C_BR);
    add(0, 0, OP_BEQ,  0, 1, 1, S_FETCH,    C_FRDY);
    add(0, 0, OP_BEQ,  0, 1, 1, S_DECODE,   C_DEC);
    add(0, 0, OP_BEQ,  0, 1, 1, S_BRANCH,   C_BR);
    add(0, 0, OP_J,    0, 1, 1, S_FETCH,    C_FRDY);
    add(0, 0, OP_J,    0, 1, 1, S_DECODE,   C_DEC);
    add(0, 0, OP_J,    0, 1, 1, S_JUMP,     C_JMP);
    add(0, 0, 6'h3f,   0, 1, 1, S_FETCH,    C_FRDY);
    add(0, 0, 6'h3f,   0, 1, 1, S_DECODE,   C_DILL);
    add(0, 0, 6'h09,   0, 1, 1, S_FETCH,    C_FRDY);
    add(0, 0, 6'h09,   0, 1, 1, S_DECODE,   C_DILL);
    // reset while MEM_RD is ready: must not reach MEM_WB
    add(0, 0, OP_LW,   0, 1, 1, S_FETCH,    C_FRDY);
    add(0, 0, OP_LW,   0, 1, 1, S_DECODE,   C_DEC);
    add(0, 0, OP_LW,   0, 1, 1, S_MEM_ADDR, C_MADR);
    add(0, 1, OP_LW,   0, 1, 1, S_MEM_RD,   C_MRD);
    add(0, 0, OP_J,    0, 1, 1, S_FETCH,    C_FRDY);
    add(0, 0, OP_J,    0, 1, 1, S_DECODE,   C_DEC);
    add(0, 0, OP_J,    0, 1, 1, S_JUMP,     C_JMP);
    // non-waiting instance, mem_ready held low throughout
    add(1, 1, OP_LW,   0, 0, 0, S_FETCH,    C_FRDY);
    add(1, 1, OP_LW,   0, 0, 1, S_FETCH,    C_FRDY);
    add(1, 0, OP_LW,   0, 0, 1, S_FETCH,    C_FRDY);
    add(1, 0, OP_LW,   0, 0, 1, S_DECODE,   C_DEC);
    add(1, 0, OP_LW,   0, 0, 1, S_MEM_ADDR, C_MADR);
    add(1, 0, OP_LW,   0, 0, 1, S_MEM_RD,   C_MRD);
    add(1, 0, OP_LW,   0, 0, 1, S_MEM_WB,   C_MWB);
    add(1, 0, OP_SW,   0, 0, 1, S_FETCH,    C_FRDY);
    add(1, 0, OP_SW,   0, 0, 1, S_DECODE,   C_DEC);
    add(1, 0, OP_SW,   0, 0, 1, S_MEM_ADDR, C_MADR);
    add(1, 0, OP_SW,   0, 0, 1, S_MEM_WR,   C_MWD);
    add(1, 0, OP_LW,   0, 0, 1, S_FETCH,    C_FRDY);
    add(1, 0, OP_LW,   0, 0, 1, S_DECODE,   C_DEC);
    add(1, 0, OP_LW,   0, 0, 1, S_MEM_ADDR, C_MADR);
    add(1, 1, OP_LW,   0, 0, 1, S_MEM_RD,   C_MRD);
    add(1, 0, OP_LW,   0, 0, 1, S_FETCH,    C_FRDY);

    for (int i = 0; i < vt.size(); i++) begin
      @(posedge clk); #1;
      drive(vt[i]);
      if (vt[i].chk) exp_q.push_back({vt[i].st, vt[i].cw});
      @(negedge clk);
      if (vt[i].chk) begin
        e   = exp_q.pop_front();
        got = vt[i].sel ? obs1 : obs0;
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL vec%0d state/ctrl got %h want %h", i, got, e);
        end
      end
    end

    // stalled lw: two wait cycles in MEM_RD -> done on cycle 6, one RF write
    @(posedge clk); #1; rst0 = 1'b1;
    @(posedge clk); #1; rst0 = 1'b0; bus0.opcode = OP_LW;
    dcnt = 0; wcnt = 0; dcyc = -1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      bus0.mem_ready = !(cyc == 3 || cyc == 4);
      @(negedge clk);
      if (bus0.reg_write) wcnt++;
      if (bus0.instr_done) begin dcnt++; dcyc = cyc; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (dcyc != 6) begin errors++; $display("FAIL lw_stall_latency got %0d want 6", dcyc); end
    checks++;
    if (dcnt != 1) begin errors++; $display("FAIL lw_stall_done got %0d want 1", dcnt); end
    checks++;
    if (wcnt != 1) begin errors++; $display("FAIL lw_stall_regwrite got %0d want 1", wcnt); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus0.state_dbg !== 4'(S_FETCH) || bus0.instr_done !== 1'b0) begin
      errors++;
      $display("FAIL lw_stall_return got st %0d done %b want st %0d done 0",
               bus0.state_dbg, bus0.instr_done, 4'(S_FETCH));
    end
    checks++;
    if (inv_bad != 0) begin errors++; $display("FAIL exclusive_strobes got %0d want 0", inv_bad); end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main control unit for the multi-cycle MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback steps.
- Drives every datapath mux select and write enable: PC, IR, register file, memory, ALU source muxes (including the sign-extend and sign-extend<<2 paths), and ALU op class.
- Sits beside the datapath top level; consumes the IR opcode and the ALU zero flag.

Parameters:
MEM_WAIT_EN, 1, 1 = memory states wait for mem_ready; 0 = mem_ready ignored and treated as 1
OPC_W, 6, opcode width; fixed at 6 for MIPS, exposed for package consistency only

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
opcode  input  6  IR[31:26], valid from DECODE onward
zero  input  1  ALU zero flag, sampled in BRANCH
mem_ready  input  1  memory access complete this cycle
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if zero
iord  output  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
ir_write  output  1  IR load
mem_to_reg  output  1  RF write data select: 0 = ALUOut, 1 = MDR
reg_dst  output  1  RF write address select: 0 = rt, 1 = rd
reg_write  output  1  RF write enable
alu_src_a  output  1  ALU A select: 0 = PC, 1 = reg A
alu_src_b  output  2  ALU B select: 00 = reg B, 01 = const 4, 10 = signext, 11 = signext<<2
alu_op  output  2  ALU op class: 00 = add, 01 = sub, 10 = funct field
pc_source  output  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target
instr_done  output  1  one-cycle pulse on the last cycle of each instruction
illegal_op  output  1  one-cycle pulse in DECODE on an unsupported opcode
state_dbg  output  4  current state encoding

Behaviour:
- Single clock domain. Reset is synchronous and active-high: with reset=1 at a rising edge of clk, state <= FETCH.
- Reset wins over all other inputs. Reset mid-instruction abandons the instruction with no writeback.
- Outputs are decoded combinationally from state, plus the mem_ready gating listed below. Every output not listed for a state is 0.
- Output values after reset are therefore the FETCH values, with pc_write/ir_write still gated by mem_ready.
- States and their outputs:
  - FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write=pc_write=mem_ready. Stay while mem_ready=0; go to DECODE when mem_ready=1.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute). Next state by opcode:
    - 000000 -> EXEC_R
    - 100011 or 101011 -> MEM_ADDR
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - 001000 -> EXEC_I
    - anything else -> FETCH, with illegal_op=1 and instr_done=1
  - MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next MEM_RD if opcode=lw, else MEM_WR.
  - MEM_RD: mem_read=1, iord=1. Hold until mem_ready, then go to MEM_WB.
  - MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Next FETCH.
  - MEM_WR: mem_write=1, iord=1. Hold until mem_ready. instr_done=mem_ready. Then go to FETCH.
  - EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10. Next R_WB.
  - R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Next FETCH.
  - EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=00. Next I_WB.
  - I_WB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Next FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1. Next FETCH. The PC update is performed by the datapath (pc_write_cond AND zero).
  - JUMP: pc_write=1, pc_source=10, instr_done=1. Next FETCH.
- Latencies with mem_ready=1 throughout:
  - lw: 5 cycles
  - sw, R-type, addi: 4 cycles
  - beq, j: 3 cycles
  - illegal opcode: 2 cycles
- Each mem_ready=0 cycle in a memory state adds 1 cycle.
- mem_write and mem_read are never both 1. pc_write and pc_write_cond are never both 1.
- Unused state encodings go to FETCH on the next edge.

Decomposition:
- Shared package mc_ctrl_pkg holds:
  - the state enum (4-bit)
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - ALUSRCB_*, ALUOP_* and PCSRC_* encodings, also consumed by the datapath and ALU control
- One natural sub-module, mc_ctrl_decode: the combinational state-to-control-word decoder. The FSM top keeps only the state register and next-state logic.

Test Plan:
- Reset held 2 cycles, then released with mem_ready=1 -> state_dbg=FETCH; mem_read=1, alu_src_b=01, pc_write=1, ir_write=1 in the first cycle.
- opcode=100011, mem_ready=1 -> states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB; reg_write=1 and mem_to_reg=1 in cycle 5; instr_done pulses once.
- opcode=101011, mem_ready low for 3 cycles in MEM_WR -> mem_write=1 held for 4 cycles; instr_done only on the mem_ready=1 cycle; reg_write never 1.
- opcode=000100, zero=1, then zero=0 -> BRANCH in cycle 3 with pc_write_cond=1 and pc_source=01 in both cases; pc_write=0.
- opcode=111111 -> DECODE asserts illegal_op=1 and instr_done=1; next state FETCH; no write enables asserted.
- lw in MEM_RD, reset asserted -> next cycle FETCH; reg_write stays 0. Repeat with MEM_WAIT_EN=0 and mem_ready=0: FETCH advances anyway.
